matrix_elementwise_unit: RTL
============================

// Module: matrix_elementwise_unit
// PURPOSE
//  Sequential, parametrised successor to the team's combinational matrix adder.
//  - Captures two NxN matrices of W-bit unsigned elements on a start pulse.
//  - Applies one of four element-wise ops (wrap/saturating add/sub).
//  - Streams results in row-major order, LANES elements per beat, over a valid/ready port.
//  - Sits between the operand buffers and the result store in the matrix datapath.
// PARAMETERS
//  N      3  matrix dimension (NxN), N>=1
//  W      8  element width in bits, W>=2
//  LANES  1  elements per output beat; must divide N*N (elaboration error otherwise)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          request new operation; honoured only in IDLE
//  mode       in   2          00 wrap add, 01 wrap sub (A-B), 10 sat add, 11 sat sub
//  a_flat     in   N*N*W      matrix A; element [i][j] at bits [(i*N+j)*W +: W]
//  b_flat     in   N*N*W      matrix B; same packing as a_flat
//  busy       out  1          high in RUN and DONE
//  out_valid  out  1          out_data/out_idx hold a valid beat
//  out_ready  in   1          consumer accepts beat when out_valid && out_ready
//  out_idx    out  clog2(N*N) row-major index of lane 0 of the current beat
//  out_data   out  LANES*W    lane k = element out_idx+k, at bits [k*W +: W]
//  overflow   out  1          sticky: some element wrapped or clamped this operation
//  done       out  1          one-cycle pulse after final beat accepted
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE. busy, out_valid, done,
//    overflow, out_idx, out_data all 0. Captured operands cleared to 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1 at edge t:
//    - Latch a_flat, b_flat, mode; clear overflow.
//    - Edge t registers beat 0, so out_valid=1 and out_idx=0 in cycle t+1.
//  - RUN, handshake rules:
//    - Beat held stable (data, idx) while out_valid && !out_ready.
//    - On acceptance of a non-final beat: next beat registered at the same edge;
//      out_valid stays 1, out_idx += LANES, no bubble.
//    - Full throughput = 1 beat/cycle.
//  - Final beat is out_idx == N*N-LANES. On its acceptance:
//    - out_valid -> 0, state -> DONE.
//    - done=1 for exactly that one DONE cycle; then IDLE.
//  - start while busy is ignored; no queuing, latched operands unaffected.
//  - Arithmetic per lane, unsigned, internally W+1 bits:
//    - wrap add: low W bits of A+B; overflow if carry-out.
//    - wrap sub: low W bits of A-B (2's compl wrap); overflow if A<B.
//    - sat add: min(A+B, 2^W-1); overflow if clamped.
//    - sat sub: max(A-B, 0); overflow if clamped.
//  - overflow is registered with each beat, set when any lane of the beat flags.
//    - Stays set until the next accepted start; readable in DONE and IDLE.
//  - Reset mid-operation: immediate abort to reset values; no done pulse.
//  - out_ready ignored when out_valid=0.
// TESTING (N=3, W=8, LANES=1 unless noted)
//  1 mode=00, A=all 10, B=all 5, out_ready=1 -> 9 beats of 15, idx 0..8 on consecutive cycles,
//    done 1 cycle after idx 8, overflow=0
//  2 mode=00, A[0][0]=200, B[0][0]=100 -> beat0 data=44, overflow=1 thereafter;
//    mode=10 same operands -> beat0=255, overflow=1
//  3 mode=11, A[1][2]=3, B[1][2]=9 -> idx5 data=0, overflow=1;
//    mode=01 same -> idx5 data=250
//  4 out_ready toggled 1,0,0,1,... -> beat held while ready=0; every idx exactly once, in order;
//    second start pulsed while busy ignored (results match first operands)
//  5 LANES=3, A[i][j]=i*3+j, B=all 1 -> 3 beats:
//    idx0 {3,2,1}, idx3 {6,5,4}, idx6 {9,8,7} (lane2..lane0)
//  6 rst_n low at beat 4 of a run -> out_valid/busy/done/overflow 0 asynchronously;
//    new start after release -> fresh run from idx0

Source files
------------

// File: rtl/matrix_elementwise_unit.sv
// matrix_elementwise_unit
//   Captures two NxN matrices of W-bit unsigned elements on a start pulse and
//   streams the element-wise result (wrap/saturating add/sub) in row-major
//   order, LANES elements per beat, over a valid/ready port.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, mode         launch request (honoured in IDLE) and op select:
//                       00 wrap add, 01 wrap sub, 10 sat add, 11 sat sub
//   a_flat, b_flat      operands, element [i][j] at bits [(i*N+j)*W +: W]
//   busy                high while a result stream is in flight (RUN/DONE)
//   out_valid/out_ready beat handshake; out_idx is the index of lane 0,
//   out_data            lane k (element out_idx+k) at bits [k*W +: W]
//   overflow            sticky per operation: some lane wrapped or clamped
//   done                one-cycle pulse after the final beat is accepted
module matrix_elementwise_unit #(
  parameter int N     = 3,
  parameter int W     = 8,
  parameter int LANES = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [1:0]                                 mode,
  input  logic [N*N*W-1:0]                           a_flat,
  input  logic [N*N*W-1:0]                           b_flat,
  output logic                                       busy,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [((N*N > 1) ? $clog2(N*N) : 1)-1:0]   out_idx,
  output logic [LANES*W-1:0]                         out_data,
  output logic                                       overflow,
  output logic                                       done
);

  localparam int NE   = N * N;
  localparam int IDXW = (NE > 1) ? $clog2(NE) : 1;

  if ((NE % LANES) != 0) begin : g_lanes_check
    $error("matrix_elementwise_unit: LANES must divide N*N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [NE*W-1:0]     a_reg, b_reg;
  logic [1:0]          mode_reg;
  logic [IDXW-1:0]     idx_reg;
  logic [LANES*W-1:0]  data_reg;
  logic                valid_reg;
  logic                ovf_reg;

  logic                idle;
  logic                launch;
  logic                accept;
  logic                last_beat;
  logic [NE*W-1:0]     a_src, b_src;
  logic [1:0]          mode_src;
  logic [IDXW-1:0]     next_idx;
  logic [LANES*W-1:0]  beat_data;
  logic [LANES-1:0]    beat_flag;

  assign idle      = (state_reg == IDLE);
  assign launch    = idle && start;
  assign accept    = (state_reg == RUN) && valid_reg && out_ready;
  assign last_beat = (idx_reg == IDXW'(NE - LANES));

  // Beat 0 is registered on the same edge the operands are captured, so in
  // IDLE the lanes read the live inputs instead of the (not yet loaded) copy.
  assign a_src    = idle ? a_flat : a_reg;
  assign b_src    = idle ? b_flat : b_reg;
  assign mode_src = idle ? mode   : mode_reg;
  assign next_idx = idle ? '0 : idx_reg + IDXW'(LANES);

  // One arithmetic lane per output element of the next beat.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IDXW:0] pos;
    logic [W-1:0]  ea, eb, res;
    logic [W:0]    sum, diff;
    logic          flag;

    assign pos = {1'b0, next_idx} + (IDXW + 1)'(gi);

    always_comb begin
      ea = '0;
      eb = '0;
      for (int e = 0; e < NE; e++) begin
        if (pos == (IDXW + 1)'(e)) begin
          ea = a_src[e*W +: W];
          eb = b_src[e*W +: W];
        end
      end
    end

    // Bit W of sum is the carry-out; bit W of diff is the borrow (A < B).
    assign sum  = {1'b0, ea} + {1'b0, eb};
    assign diff = {1'b0, ea} - {1'b0, eb};

    always_comb begin
      res  = sum[W-1:0];
      flag = sum[W];
      case (mode_src)
        2'b00: begin res = sum[W-1:0];                    flag = sum[W];  end
        2'b01: begin res = diff[W-1:0];                   flag = diff[W]; end
        2'b10: begin res = sum[W]  ? '1 : sum[W-1:0];     flag = sum[W];  end
        default: begin res = diff[W] ? '0 : diff[W-1:0];  flag = diff[W]; end
      endcase
    end

    assign beat_data[gi*W +: W] = res;
    assign beat_flag[gi]        = flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (launch) begin
      a_reg     <= a_flat;
      b_reg     <= b_flat;
      mode_reg  <= mode;
      idx_reg   <= '0;
      data_reg  <= beat_data;
      valid_reg <= 1'b1;
      ovf_reg   <= |beat_flag;
    end else if (accept) begin
      if (last_beat) begin
        valid_reg <= 1'b0;
      end else begin
        idx_reg  <= next_idx;
        data_reg <= beat_data;
        ovf_reg  <= ovf_reg | (|beat_flag);
      end
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign out_valid = valid_reg;
  assign out_idx   = idx_reg;
  assign out_data  = data_reg;
  assign overflow  = ovf_reg;

endmodule
